// File: rtl/parity_rx_chk.sv
// parity_rx_chk: parity checker feeding a 2-entry FIFO with error counter
module parity_rx_chk #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_par,
   input  logic              sel,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              err_sticky,
   input  logic              clr_err
);
   logic [DATA_W-1:0] mem_data [2];
   logic [1:0]        mem_err;
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        count;
   logic              push;
   logic              pop;
   logic              exp_par;
   logic              word_err;
   // handshakes come from registered occupancy only, so out_ready never reaches in_ready
   always_comb begin
      in_ready  = count != 2'd2;
      out_valid = count != 2'd0;
      push      = in_valid & in_ready;
      pop       = out_valid & out_ready;
      exp_par   = sel ? ^in_data : ~^in_data;
      word_err  = in_par != exp_par;
      out_data  = mem_data[rd_ptr];
      out_err   = mem_err[rd_ptr];
   end
   // fifo storage and pointers; no bypass, so a pushed word appears one edge later
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) mem_data[i] <= '0;
         mem_err <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
      end else begin
         if (push) begin
            mem_data[wr_ptr] <= in_data;
            mem_err[wr_ptr]  <= word_err;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end
   // saturating error count and sticky flag; clear wins over a same-cycle error
   always_ff @(posedge clk) begin
      if (rst || clr_err) begin
         err_cnt    <= '0;
         err_sticky <= 1'b0;
      end else if (push && word_err) begin
         err_cnt    <= &err_cnt ? err_cnt : err_cnt + 1'b1;
         err_sticky <= 1'b1;
      end
   end
endmodule

// File: tb/tb_parity_rx_chk.sv
// tb_parity_rx_chk: directed self-checking bench for parity_rx_chk
module tb_parity_rx_chk;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_par, sel, out_ready, clr_err;
   logic [31:0] in_data;
   logic        in_ready, out_valid, out_err, err_sticky;
   logic [31:0] out_data;
   logic [15:0] err_cnt;
   logic        in_ready2, out_valid2, out_err2, err_sticky2;
   logic [31:0] out_data2;
   logic [1:0]  err_cnt2;
   int          passed = 0;
   int          total = 0;

   parity_rx_chk dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_par(in_par), .sel(sel), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
      .err_cnt(err_cnt), .err_sticky(err_sticky), .clr_err(clr_err)
   );

   parity_rx_chk #(.DATA_W(32), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_data(in_data), .in_par(in_par), .sel(sel), .out_valid(out_valid2),
      .out_ready(out_ready), .out_data(out_data2), .out_err(out_err2),
      .err_cnt(err_cnt2), .err_sticky(err_sticky2), .clr_err(clr_err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic drive(input logic [31:0] d, input logic s, input logic bad);
      in_valid = 1'b1;
      in_data  = d;
      sel      = s;
      in_par   = (s ? ^d : ~^d) ^ bad;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_par = 1'b0; sel = 1'b0;
      out_ready = 1'b1; clr_err = 1'b0;
      tick; tick;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_err_sticky", err_sticky, 0);

      rst = 1'b0;
      in_valid = 1'b1; in_data = 32'h1; in_par = 1'b1; sel = 1'b1;
      #1;
      chk("no_bypass", out_valid, 0);
      tick;
      in_valid = 1'b0;
      chk("odd_valid", out_valid, 1);
      chk("odd_data", out_data, 32'h1);
      chk("odd_err", out_err, 0);
      chk("odd_cnt", err_cnt, 0);

      in_valid = 1'b1; in_data = 32'h1; in_par = 1'b1; sel = 1'b0;
      tick;
      chk("even_bad_valid", out_valid, 1);
      chk("even_bad_err", out_err, 1);
      chk("even_bad_cnt", err_cnt, 1);
      chk("even_bad_sticky", err_sticky, 1);
      in_data = 32'h0; in_par = 1'b1; sel = 1'b0;
      tick;
      in_valid = 1'b0;
      chk("even_ok_data", out_data, 0);
      chk("even_ok_err", out_err, 0);
      chk("even_ok_cnt", err_cnt, 1);
      chk("even_ok_sticky", err_sticky, 1);
      tick;
      chk("drained", out_valid, 0);

      out_ready = 1'b0;
      drive(32'hA5A5A5A5, 1'b1, 1'b0);
      tick;
      drive(32'h5A5A5A5A, 1'b1, 1'b0);
      tick;
      chk("full_in_ready", in_ready, 0);
      chk("full_head", out_data, 32'hA5A5A5A5);
      drive(32'hDEADBEEF, 1'b1, 1'b0);
      tick;
      in_valid = 1'b0;
      chk("hold_data", out_data, 32'hA5A5A5A5);
      chk("hold_valid", out_valid, 1);
      chk("hold_err", out_err, 0);
      out_ready = 1'b1;
      tick;
      chk("bp_second", out_data, 32'h5A5A5A5A);
      chk("bp_in_ready", in_ready, 1);
      tick;
      chk("bp_no_extra", out_valid, 0);

      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      chk("clr_cnt", err_cnt, 0);
      chk("clr_sticky", err_sticky, 0);
      for (int i = 0; i < 5; i++) begin
         drive(32'h0, 1'b0, 1'b1);
         tick;
      end
      in_valid = 1'b0;
      chk("sat_cnt2", err_cnt2, 3);
      chk("sat_cnt16", err_cnt, 5);
      chk("sat_sticky2", err_sticky2, 1);
      chk("sat_err", out_err, 1);
      drive(32'h0000_00F0, 1'b1, 1'b1);
      clr_err = 1'b1;
      tick;
      clr_err = 1'b0;
      in_valid = 1'b0;
      chk("clr_pri_cnt2", err_cnt2, 0);
      chk("clr_pri_sticky2", err_sticky2, 0);
      chk("clr_pri_cnt16", err_cnt, 0);
      chk("clr_pri_data", out_data, 32'h0000_00F0);
      chk("clr_pri_err", out_err, 1);
      tick;
      chk("clr_drained", out_valid, 0);

      out_ready = 1'b0;
      drive(32'h3, 1'b1, 1'b0);
      tick;
      drive(32'h0, 1'b1, 1'b1);
      tick;
      chk("pre_rst_full", in_ready, 0);
      chk("pre_rst_cnt", err_cnt, 1);
      rst = 1'b1;
      drive(32'h77, 1'b1, 1'b1);
      tick;
      rst = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_cnt", err_cnt, 0);
      chk("mid_rst_sticky", err_sticky, 0);
      chk("mid_rst_data", out_data, 0);
      out_ready = 1'b1;
      tick; tick;
      chk("no_stale", out_valid, 0);

      drive(32'd100, 1'b1, 1'b0);
      tick;
      chk("pp_first", out_data, 32'd100);
      for (int i = 0; i < 10; i++) begin
         drive(32'd101 + i, 1'b1, 1'b0);
         tick;
         chk("pp_data", out_data, 32'd101 + i);
         chk("pp_occ", {out_valid, in_ready}, 2'b11);
      end
      in_valid = 1'b0;
      tick;
      chk("pp_drained", out_valid, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
